// File: rtl/fsm_iter_ctrl_pkg.sv
// Shared definitions for the iterative-operation controller: one-hot state
// indices, the state encoding and a one-hot legality helper.
package fsm_iter_pkg;

  localparam int ST_W    = 5;

  // Bit positions of each state inside the one-hot state vector
  localparam int S_IDLE  = 0;
  localparam int S_INIT  = 1;
  localparam int S_ITER  = 2;
  localparam int S_FINAL = 3;
  localparam int S_ERR   = 4;

  // All-zero state vector (never legal; useful as a base when building codes)
  localparam logic [ST_W-1:0] ST_NONE = 5'b00000;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 5'b00001,
    ST_INIT  = 5'b00010,
    ST_ITER  = 5'b00100,
    ST_FINAL = 5'b01000,
    ST_ERR   = 5'b10000
  } state_e;

  // True when exactly one bit of the state vector is set
  function automatic logic is_onehot(input logic [ST_W-1:0] s);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < ST_W; i++) begin
      n = n + 32'(s[i]);
    end
    return (n == 32'd1);
  endfunction

endpackage

// File: rtl/fsm_iter_ctrl_if.sv
// Bundle of the controller's handshake (master side) and datapath signals.
// The controller uses the slave modport; the requester/datapath uses master.
interface fsm_iter_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             zero;
  logic             abort;
  logic             ack;
  logic             do_init;
  logic             do_iter;
  logic             busy;
  logic             ready;
  logic             timeout;
  logic [CNT_W-1:0] iter_cnt;
  logic             state_err;

  modport master (
    output start, zero, abort, ack,
    input  do_init, do_iter, busy, ready, timeout, iter_cnt, state_err
  );

  modport slave (
    input  start, zero, abort, ack,
    output do_init, do_iter, busy, ready, timeout, iter_cnt, state_err
  );
endinterface

// File: rtl/fsm_iter_ctrl_iter_counter.sv
// Iteration counter for the controller: synchronous clear, increment, and a
// flag that is high when the next increment would reach LIMIT.
module iter_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             limit
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear has priority over increment, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (clr) begin
      r_cnt <= CNT_ZERO;
    end else if (inc) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt   = r_cnt;
  assign limit = (r_cnt == LIMIT_M1);

endmodule

// File: rtl/fsm_iter_ctrl.sv
// One-hot controller for an iterative datapath operation:
// IDLE -> INIT -> ITER (until zero / limit) -> FINAL or ERR -> IDLE.
// Abort cancels from anywhere; illegal one-hot codes recover to IDLE with a
// one-cycle state_err pulse. All outputs decode directly from state flops.
module fsm_iter_ctrl
  import fsm_iter_pkg::*;
#(
  parameter int MAX_ITER   = 255,
  parameter int CNT_W      = 8,
  parameter int READY_HOLD = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fsm_iter_ctrl_if.slave bus
);

  // Reject iteration limits that the counter could not represent
  if (MAX_ITER < 1 || 64'(MAX_ITER) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_max_iter
    $fatal(1, "fsm_iter_ctrl: MAX_ITER out of range for CNT_W");
  end

  state_e           r_state;
  logic             r_state_err;
  logic             w_legal;
  logic             w_clr;
  logic             w_inc;
  logic             w_limit;
  logic [CNT_W-1:0] w_cnt;

  assign w_legal = is_onehot(r_state);

  // Exact-code compares already imply a legal state, so an illegal vector
  // neither clears nor advances the count.
  assign w_clr = (r_state == ST_INIT);
  assign w_inc = (r_state == ST_ITER);

  iter_counter #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_ITER)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_inc),
    .cnt   (w_cnt),
    .limit (w_limit)
  );

  // State register and error pulse: legality check first, then abort > zero > limit > ack/start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_state_err <= 1'b0;
    end else if (!w_legal) begin
      r_state     <= ST_IDLE;
      r_state_err <= 1'b1;
    end else begin
      r_state_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state <= ST_INIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_INIT: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.zero) begin
            r_state <= ST_FINAL;
          end else begin
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.zero) begin
            r_state <= ST_FINAL;
          end else if (w_limit) begin
            r_state <= ST_ERR;
          end else begin
            r_state <= ST_ITER;
          end
        end
        ST_FINAL: begin
          if (READY_HOLD == 0) begin
            r_state <= ST_IDLE;
          end else if (bus.abort || bus.ack) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_FINAL;
          end
        end
        ST_ERR: begin
          if (bus.abort || bus.ack) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_ERR;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_state_err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.do_init   = r_state[S_INIT];
  assign bus.do_iter   = r_state[S_ITER];
  assign bus.busy      = r_state[S_INIT] | r_state[S_ITER];
  assign bus.ready     = r_state[S_FINAL];
  assign bus.timeout   = r_state[S_ERR];
  assign bus.iter_cnt  = w_cnt;
  assign bus.state_err = r_state_err;

endmodule

// File: tb/tb_fsm_iter_ctrl.sv
// Self-checking bench for fsm_iter_ctrl. Three instances cover the hold and
// pulse ready modes and a small timeout limit. A phase-level model predicts
// every output each cycle; literal checks pin key numbers of each scenario.
module tb_fsm_iter_ctrl;
  import fsm_iter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  fsm_iter_ctrl_if #(.CNT_W(8)) if_a ();
  fsm_iter_ctrl_if #(.CNT_W(8)) if_b ();
  fsm_iter_ctrl_if #(.CNT_W(3)) if_c ();

  fsm_iter_ctrl #(.MAX_ITER(255), .CNT_W(8), .READY_HOLD(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fsm_iter_ctrl #(.MAX_ITER(255), .CNT_W(8), .READY_HOLD(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fsm_iter_ctrl #(.MAX_ITER(4),   .CNT_W(3), .READY_HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  bit    cmp_on = 1'b0;
  int    cur    = 0;

  int    max_it [3] = '{255, 255, 4};
  bit    hold   [3] = '{1'b1, 1'b0, 1'b1};
  bit    in_s [3];
  bit    in_z [3];
  bit    in_a [3];
  bit    in_k [3];

  // Model: phase name, count of ITER edges, pending error pulse
  string m_ph  [3];
  int    m_cnt [3];
  bit    m_err [3];

  int t_init, t_iter, t_busy, t_rdy, t_tmo;

  // Observed outputs: {err, timeout, ready, busy, do_iter, do_init, cnt[7:0]}
  function automatic logic [13:0] get_obs(input int d);
    case (d)
      0:       return {if_a.state_err, if_a.timeout, if_a.ready, if_a.busy, if_a.do_iter, if_a.do_init, if_a.iter_cnt};
      1:       return {if_b.state_err, if_b.timeout, if_b.ready, if_b.busy, if_b.do_iter, if_b.do_init, if_b.iter_cnt};
      default: return {if_c.state_err, if_c.timeout, if_c.ready, if_c.busy, if_c.do_iter, if_c.do_init, 5'd0, if_c.iter_cnt};
    endcase
  endfunction

  function automatic logic [13:0] expected(input int d);
    logic [13:0] e;
    e = 14'd0;
    e[7:0] = m_cnt[d][7:0];
    e[13]  = m_err[d];
    if (m_ph[d] == "init") begin e[8] = 1'b1; e[10] = 1'b1; end
    if (m_ph[d] == "iter") begin e[9] = 1'b1; e[10] = 1'b1; end
    if (m_ph[d] == "done") e[11] = 1'b1;
    if (m_ph[d] == "tmo")  e[12] = 1'b1;
    return e;
  endfunction

  task automatic set_in(input int d, input bit s, input bit z, input bit a, input bit k);
    in_s[d] = s; in_z[d] = z; in_a[d] = a; in_k[d] = k;
    case (d)
      0:       begin if_a.start = s; if_a.zero = z; if_a.abort = a; if_a.ack = k; end
      1:       begin if_b.start = s; if_b.zero = z; if_b.abort = a; if_b.ack = k; end
      default: begin if_c.start = s; if_c.zero = z; if_c.abort = a; if_c.ack = k; end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ph[d] = "idle"; m_cnt[d] = 0; m_err[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    bit err_n;
    err_n = 1'b0;
    if (m_ph[d] == "bad") begin
      m_ph[d] = "idle"; err_n = 1'b1;
    end else if (m_ph[d] == "idle") begin
      if (in_s[d] && !in_a[d]) m_ph[d] = "init";
    end else if (m_ph[d] == "init") begin
      m_cnt[d] = 0;
      if (in_a[d])      m_ph[d] = "idle";
      else if (in_z[d]) m_ph[d] = "done";
      else              m_ph[d] = "iter";
    end else if (m_ph[d] == "iter") begin
      m_cnt[d] = m_cnt[d] + 1;
      if (in_a[d])                     m_ph[d] = "idle";
      else if (in_z[d])                m_ph[d] = "done";
      else if (m_cnt[d] == max_it[d])  m_ph[d] = "tmo";
    end else if (m_ph[d] == "done") begin
      if (!hold[d] || in_k[d] || in_a[d]) m_ph[d] = "idle";
    end else if (m_ph[d] == "tmo") begin
      if (in_k[d] || in_a[d]) m_ph[d] = "idle";
    end
    m_err[d] = err_n;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
  endtask

  task automatic clr_tally();
    t_init = 0; t_iter = 0; t_busy = 0; t_rdy = 0; t_tmo = 0;
  endtask

  // One clock: model advances on the edge, tallies taken mid-cycle
  task automatic cyc();
    logic [13:0] o;
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    @(negedge clk);
    #1;
    o = get_obs(cur);
    if (o[8])  t_init++;
    if (o[9])  t_iter++;
    if (o[10]) t_busy++;
    if (o[11]) t_rdy++;
    if (o[12]) t_tmo++;
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 3; d++) begin
        n_chk = n_chk + 1;
        if (get_obs(d) === expected(d)) n_pass = n_pass + 1;
        else $display("FAIL cycle_cmp dut%0d t=%0t got=%h exp=%h", d, $time, get_obs(d), expected(d));
      end
    end
  end

  initial begin
    logic [13:0] o;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    for (int d = 0; d < 3; d++) chk($sformatf("reset_state_dut%0d", d), int'(get_obs(d)), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // 1: zero already high at INIT, ready held until ack
    cur = 0; clr_tally();
    set_in(0, 1'b1, 1'b1, 1'b0, 1'b0); cyc();
    chk("t1_do_init_n1", int'(if_a.do_init), 1);
    set_in(0, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t1_ready_n2", int'(if_a.ready), 1);
    chk("t1_cnt", int'(if_a.iter_cnt), 0);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); cyc(); cyc();
    chk("t1_ready_hold_cycles", t_rdy, 4);
    chk("t1_no_iter", t_iter, 0);
    chk("t1_init_cycles", t_init, 1);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    chk("t1_ready_after_ack", int'(if_a.ready), 0);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: three iterations, pulse-mode ready
    cur = 1; clr_tally();
    set_in(1, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); cyc(); cyc();
    set_in(1, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t2_cnt", int'(if_b.iter_cnt), 3);
    chk("t2_ready", int'(if_b.ready), 1);
    set_in(1, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); cyc();
    chk("t2_iter_cycles", t_iter, 3);
    chk("t2_busy_cycles", t_busy, 4);
    chk("t2_ready_pulse", t_rdy, 1);

    // 3: timeout at MAX_ITER=4, held until ack
    cur = 2; clr_tally();
    set_in(2, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc();
    chk("t3_timeout", int'(if_c.timeout), 1);
    chk("t3_cnt", int'(if_c.iter_cnt), 4);
    cyc(); cyc(); cyc();
    chk("t3_iter_cycles", t_iter, 4);
    chk("t3_timeout_cycles", t_tmo, 4);
    chk("t3_no_ready", t_rdy, 0);
    set_in(2, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    chk("t3_timeout_after_ack", int'(if_c.timeout), 0);
    chk("t3_cnt_kept", int'(if_c.iter_cnt), 4);
    set_in(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: abort beats zero in ITER; abort with start in IDLE
    cur = 0; clr_tally();
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); cyc();
    set_in(0, 1'b0, 1'b1, 1'b1, 1'b0); cyc();
    chk("t4_busy_after_abort", int'(if_a.busy), 0);
    chk("t4_cnt", int'(if_a.iter_cnt), 2);
    set_in(0, 1'b1, 1'b0, 1'b1, 1'b0); cyc();
    chk("t4_abort_start_idle", int'(if_a.do_init), 0);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t4_no_ready_timeout", t_rdy + t_tmo, 0);

    // 5: illegal INIT|ITER vector recovers to IDLE with one error pulse
    cur = 0; clr_tally();
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);
    force dut_a.r_state = state_e'(5'b00110);
    m_ph[0] = "bad";
    #1;
    release dut_a.r_state;
    cyc();
    chk("t5_state_err", int'(if_a.state_err), 1);
    chk("t5_busy", int'(if_a.busy), 0);
    chk("t5_cnt_unchanged", int'(if_a.iter_cnt), 2);
    cyc();
    chk("t5_state_err_one_cycle", int'(if_a.state_err), 0);
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    set_in(0, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t5_recover_ready", int'(if_a.ready), 1);
    chk("t5_recover_cnt", int'(if_a.iter_cnt), 1);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset in the middle of ITER
    cur = 0; clr_tally();
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(); cyc();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    o = get_obs(0);
    chk("t6_do_iter_drop", int'(o[9]), 0);
    chk("t6_busy_drop", int'(o[10]), 0);
    chk("t6_all_zero", int'(o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6_init_after_reset", int'(if_a.do_init), 1);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();
    chk("t6_cnt_cleared", int'(if_a.iter_cnt), 0);
    cyc();
    set_in(0, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    chk("t6_ready", int'(if_a.ready), 1);
    chk("t6_cnt", int'(if_a.iter_cnt), 2);
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b1); cyc();
    set_in(0, 1'b0, 1'b0, 1'b0, 1'b0); cyc();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_iter_ctrl.md
Name: fsm_iter_ctrl

Overview:
Parametrised one-hot controller for iterative datapath operations (start → init → iterate until zero → final).
Adds a bounded iteration count with a timeout, an abort input, and a selectable ready handshake (pulse or hold-until-ack).
Adds synthesizable one-hot legality checking with recovery.
Sits between the datapath (zero, do_init, do_iter) and the requesting master (start, abort, ack, ready, timeout).

Parameters:
MAX_ITER, 255, max ITER cycles before timeout; legal range 1..2^CNT_W-1
CNT_W, 8, width of iteration counter / iter_cnt output
READY_HOLD, 1, 1: ready/timeout held until ack; 0: ready is a one-cycle pulse (timeout still waits for ack)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  request new operation; sampled only in IDLE
zero  input  1  datapath termination flag
abort  input  1  cancel current operation, highest priority
ack  input  1  master acknowledges ready/timeout
do_init  output  1  datapath initialise command
do_iter  output  1  datapath iteration command
busy  output  1  operation in progress (INIT or ITER)
ready  output  1  operation completed normally
timeout  output  1  operation terminated by MAX_ITER limit
iter_cnt  output  CNT_W  number of ITER cycles of the last/current operation
state_err  output  1  one-cycle pulse: illegal one-hot state detected

Behaviour:
- One clock (clk); reset rst_n asynchronous, active low. All state in one always block per flop group with async reset.
- State is 5 one-hot flops: IDLE, INIT, ITER, FINAL, ERR.
- Reset values: IDLE=1, all other state bits 0; iter_cnt=0; state_err=0. All Moore outputs are therefore 0.
- Outputs (Moore, from state flops only):
  - do_init=INIT
  - do_iter=ITER
  - busy=INIT|ITER
  - ready=FINAL
  - timeout=ERR
- Priority in every state: abort > zero > timeout limit > ack/start.
- Transitions:
  - IDLE: start & ~abort → INIT; else stay.
  - INIT (exactly 1 cycle): abort → IDLE; zero → FINAL; else → ITER. iter_cnt cleared to 0 on this edge.
  - ITER: iter_cnt increments by 1 on every edge spent in ITER.
    - abort → IDLE
    - else zero → FINAL
    - else iter_cnt==MAX_ITER-1 → ERR, with iter_cnt becoming MAX_ITER
    - else stay
  - FINAL:
    - READY_HOLD=0: → IDLE next cycle unconditionally.
    - READY_HOLD=1: stay until ack or abort → IDLE.
  - ERR: stay until ack or abort → IDLE.
- ack outside FINAL/ERR is ignored. start outside IDLE is ignored; it is not queued.
- iter_cnt holds its value in FINAL, ERR and IDLE until the next INIT. It never wraps, because MAX_ITER ≤ 2^CNT_W-1.
- Sequence with zero after k iterations: do_iter high exactly k cycles, then iter_cnt=k while ready=1. With zero at INIT: k=0, no do_iter.
- Latency: start sampled at edge n → do_init high in cycle n+1 → earliest ready in cycle n+2.
- Illegal state (popcount of state bits ≠ 1) on any edge:
  - next state forced to IDLE only (other bits 0);
  - state_err=1 for exactly that following cycle;
  - iter_cnt unchanged.
  - This check takes precedence over all normal transitions.
- Reset mid-operation: outputs drop immediately on rst_n fall, not at a clock edge. After rst_n rises, first start is handled normally.
- Elaboration-time check: MAX_ITER < 1 or MAX_ITER > 2^CNT_W-1 is a fatal error.

Decomposition:
- Shared package fsm_iter_pkg:
  - one-hot state index constants S_IDLE=0, S_INIT=1, S_ITER=2, S_FINAL=3, S_ERR=4
  - ST_W=5
  - helper constant for an all-zero state vector
- One sub-module: iter_counter, parametrised by CNT_W.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: cnt, and limit flag cnt==LIMIT-1 (LIMIT parameter).
  - fsm_iter_ctrl keeps the state logic; iter_counter holds the count.

Test Plan:
1. Zero at INIT: start pulse with zero=1 from start, READY_HOLD=1 → do_init 1 cycle, ready from cycle n+2 held until ack, do_iter never high, iter_cnt=0; ack → IDLE next edge.
2. Three iterations: zero rises after 3 ITER cycles → do_iter high exactly 3 cycles, busy high 4 cycles, iter_cnt=3. With READY_HOLD=0, ready is a single-cycle pulse.
3. Timeout: MAX_ITER=4, CNT_W=3, zero held 0 → do_iter 4 cycles, then timeout=1 with iter_cnt=4, held until ack.
4. Abort priority: abort=1 and zero=1 in the same ITER cycle → IDLE next edge, ready and timeout never assert. Abort with start in IDLE → stays IDLE.
5. Illegal state: force INIT and ITER both 1 → next cycle IDLE only, state_err high exactly 1 cycle; next start completes normally.
6. Async reset: rst_n low mid-ITER between clock edges → do_iter/busy drop to 0 immediately and IDLE=1. Release, then start → normal sequence with iter_cnt cleared at INIT.
